wm_game_ctrl: RTL and testbench

- Round sequencer for the whack-a-mole alarm-dismiss game.
- On an alarm trigger it sounds the buzzer and generates a pseudo-random mole number. It then arms and clears the WM_timer for each round, scores each round from the timer's right/done result, and silences the alarm after HITS_NEEDED hits.
- Sits between the alarm-compare logic, the push buttons and one WM_timer instance.

---
 rtl/wm_game_ctrl.sv | 142 ++++++++++++++
 tb/tb_wm_game_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wm_game_ctrl.sv
// Whack-a-mole round sequencer: sounds the alarm, runs WM_timer rounds, scores hits,
// and dismisses the alarm after HITS_NEEDED hits within one attempt of MAX_ROUNDS rounds.
module wm_game_ctrl #(
    parameter int unsigned HITS_NEEDED = 5,
    parameter int unsigned MAX_ROUNDS  = 10,
    parameter int unsigned GAP_CYCLES  = 100,
    parameter int unsigned WATCHDOG    = 1023,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_trig,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
    input  logic       B4,
    input  logic       timer_right,
    input  logic       timer_done,
    output logic       timer_enable,
    output logic       timer_reset,
    output logic [1:0] rn,
    output logic [3:0] mole_led,
    output logic       alarm_on,
    output logic [3:0] hits,
    output logic [3:0] rounds,
    output logic       game_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_ACTIVE, S_SCORE, S_GAP, S_WIN
    } state_t;

    localparam logic [3:0]  HITS_L   = 4'(HITS_NEEDED);
    localparam logic [3:0]  ROUNDS_L = 4'(MAX_ROUNDS);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WD_LAST  = 16'(WATCHDOG - 1);

    state_t      state;
    logic [7:0]  lfsr;
    logic [15:0] wd_cnt;
    logic [15:0] gap_cnt;
    logic        right_q;
    logic        armed;
    logic [3:0]  hits_inc;
    logic [3:0]  rounds_inc;
    logic        lfsr_fb;

    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign hits_inc   = hits + {3'b000, right_q};
    assign rounds_inc = rounds + 4'd1;

    // armed stays low for the first edge after reset release, so a trigger
    // coinciding with release is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            right_q      <= 1'b0;
            armed        <= 1'b0;
            timer_enable <= 1'b0;
            timer_reset  <= 1'b1;
            rn           <= '0;
            mole_led     <= '0;
            alarm_on     <= 1'b0;
            hits         <= '0;
            rounds       <= '0;
            game_done    <= 1'b0;
        end else begin
            lfsr      <= {lfsr[6:0], lfsr_fb};
            armed     <= 1'b1;
            game_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alarm_trig && armed) begin
                        state    <= S_CLEAR;
                        alarm_on <= 1'b1;
                        hits     <= '0;
                        rounds   <= '0;
                    end
                end
                S_CLEAR: begin
                    state       <= S_ARM;
                    timer_reset <= 1'b0;
                    rn          <= (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
                end
                S_ARM: begin
                    if ({B1, B2, B3, B4} == 4'b0000) begin
                        state        <= S_ACTIVE;
                        wd_cnt       <= '0;
                        timer_enable <= 1'b1;
                        mole_led     <= 4'b0001 << rn;
                    end
                end
                S_ACTIVE: begin
                    if (timer_done || wd_cnt == WD_LAST) begin
                        state        <= S_SCORE;
                        right_q      <= timer_done & timer_right;
                        timer_enable <= 1'b0;
                        mole_led     <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                S_SCORE: begin
                    timer_reset <= 1'b1;
                    gap_cnt     <= '0;
                    if (hits_inc == HITS_L) begin
                        state     <= S_WIN;
                        hits      <= hits_inc;
                        rounds    <= rounds_inc;
                        alarm_on  <= 1'b0;
                        game_done <= 1'b1;
                    end else if (rounds_inc == ROUNDS_L) begin
                        state  <= S_GAP;
                        hits   <= '0;
                        rounds <= '0;
                    end else begin
                        state  <= S_GAP;
                        hits   <= hits_inc;
                        rounds <= rounds_inc;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_CLEAR;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_WIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wm_game_ctrl.sv
// Directed bench for wm_game_ctrl: the bench plays the WM_timer role and checks
// outputs with immediate assertions at each step.
module tb_wm_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_trig = 1'b0;
    logic       B1 = 1'b0, B2 = 1'b0, B3 = 1'b0, B4 = 1'b0;
    logic       timer_right = 1'b0;
    logic       timer_done = 1'b0;
    logic       timer_enable, timer_reset, alarm_on, game_done;
    logic [1:0] rn;
    logic [3:0] mole_led, hits, rounds;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned win_cnt = 0;
    int unsigned gd_cnt = 0;
    logic        te_prev = 1'b0;
    logic [7:0]  m_lfsr;
    logic [1:0]  exp_rn;

    wm_game_ctrl #(
        .HITS_NEEDED(5),
        .MAX_ROUNDS (10),
        .GAP_CYCLES (4),
        .WATCHDOG   (20),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alarm_trig  (alarm_trig),
        .B1          (B1),
        .B2          (B2),
        .B3          (B3),
        .B4          (B4),
        .timer_right (timer_right),
        .timer_done  (timer_done),
        .timer_enable(timer_enable),
        .timer_reset (timer_reset),
        .rn          (rn),
        .mole_led    (mole_led),
        .alarm_on    (alarm_on),
        .hits        (hits),
        .rounds      (rounds),
        .game_done   (game_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Fibonacci, taps 8,6,5,4, free-running from the seed.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        if (game_done === 1'b1) gd_cnt++;
        if (timer_enable === 1'b1 && te_prev !== 1'b1) win_cnt++;
        te_prev = timer_enable;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acts as WM_timer: waits for the enable, then reports done with the given result.
    task automatic run_round(input logic r);
        int unsigned n;
        n = 0;
        while (timer_enable !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (timer_enable !== 1'b1) begin
            chk("round_wait_timeout", 16'(timer_enable), 16'd1);
            return;
        end
        timer_done  = 1'b1;
        timer_right = r;
        @(negedge clk);
        timer_done  = 1'b0;
        timer_right = 1'b0;
    endtask

    initial begin
        int unsigned n;
        reset = 1'b1;
        #1 reset = 1'b0;
        #20;
        chk("rst_timer_reset", 16'(timer_reset), 16'd1);
        chk("rst_alarm_on",    16'(alarm_on), 16'd0);
        chk("rst_rn",          16'(rn), 16'd0);
        chk("rst_mole_led",    16'(mole_led), 16'd0);
        chk("rst_hits",        16'(hits), 16'd0);
        chk("rst_rounds",      16'(rounds), 16'd0);
        chk("rst_timer_en",    16'(timer_enable), 16'd0);
        chk("rst_game_done",   16'(game_done), 16'd0);

        // Full winning game: every round is a hit.
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        win_cnt = 0;
        gd_cnt  = 0;
        alarm_trig = 1'b1;
        @(negedge clk);
        alarm_trig = 1'b0;
        chk("clear_alarm_on",    16'(alarm_on), 16'd1);
        chk("clear_timer_reset", 16'(timer_reset), 16'd1);
        chk("clear_timer_en",    16'(timer_enable), 16'd0);
        exp_rn = (m_lfsr[1:0] == 2'd0) ? 2'd1 : m_lfsr[1:0];
        @(negedge clk);
        chk("arm_rn",          16'(rn), 16'(exp_rn));
        chk("arm_timer_reset", 16'(timer_reset), 16'd0);
        chk("arm_timer_en",    16'(timer_enable), 16'd0);
        @(negedge clk);
        chk("active_timer_en", 16'(timer_enable), 16'd1);
        chk("active_mole_led", 16'(mole_led), 16'(4'b0001 << exp_rn));
        for (int i = 1; i <= 5; i++) begin
            run_round(1'b1);
            chk("score_mole_off", 16'(mole_led), 16'd0);
            @(negedge clk);
            if (i < 5) begin
                chk("win_hits",   16'(hits), 16'(i));
                chk("win_rounds", 16'(rounds), 16'(i));
                chk("win_alarm",  16'(alarm_on), 16'd1);
            end else begin
                chk("win_game_done", 16'(game_done), 16'd1);
                chk("win_alarm_off", 16'(alarm_on), 16'd0);
                chk("win_final_hits",   16'(hits), 16'd5);
                chk("win_final_rounds", 16'(rounds), 16'd5);
                chk("win_timer_reset",  16'(timer_reset), 16'd1);
            end
        end
        @(negedge clk);
        chk("win_pulse_end", 16'(game_done), 16'd0);
        repeat (20) @(negedge clk);
        chk("win_windows",     16'(win_cnt), 16'd5);
        chk("win_pulses",      16'(gd_cnt), 16'd1);
        chk("idle_hits_hold",  16'(hits), 16'd5);
        chk("idle_alarm_off",  16'(alarm_on), 16'd0);

        // Held button blocks ARM until released.
        B2 = 1'b1;
        alarm_trig = 1'b1;
        @(negedge clk);
        alarm_trig = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_timer_en",    16'(timer_enable), 16'd0);
        chk("held_timer_reset", 16'(timer_reset), 16'd0);
        chk("held_hits_clear",  16'(hits), 16'd0);
        chk("held_rounds_clr",  16'(rounds), 16'd0);
        B2 = 1'b0;
        @(negedge clk);
        chk("release_active", 16'(timer_enable), 16'd1);

        // Ten misses exhaust the attempt; counters clear and play continues.
        for (int i = 1; i <= 10; i++) begin
            run_round(1'b0);
            @(negedge clk);
            if (i < 10) begin
                chk("miss_rounds", 16'(rounds), 16'(i));
                chk("miss_hits",   16'(hits), 16'd0);
            end else begin
                chk("exhaust_rounds", 16'(rounds), 16'd0);
                chk("exhaust_hits",   16'(hits), 16'd0);
                chk("exhaust_alarm",  16'(alarm_on), 16'd1);
            end
        end
        n = 0;
        while (timer_enable !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gap_to_active", 16'(n), 16'd6);

        // Watchdog: timer never reports done.
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (timer_enable === 1'b1) n++;
            else break;
        end
        chk("wd_active_len", 16'(n), 16'd20);
        @(negedge clk);
        chk("wd_rounds", 16'(rounds), 16'd1);
        chk("wd_hits",   16'(hits), 16'd0);

        // Reset in the middle of ACTIVE.
        n = 0;
        while (timer_enable !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_active", 16'(timer_enable), 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_timer_en", 16'(timer_enable), 16'd0);
        chk("mid_rst_alarm",    16'(alarm_on), 16'd0);
        chk("mid_rst_mole",     16'(mole_led), 16'd0);
        chk("mid_rst_treset",   16'(timer_reset), 16'd1);
        @(negedge clk);
        reset = 1'b1;
        alarm_trig = 1'b1;
        @(negedge clk);
        alarm_trig = 1'b0;
        repeat (3) @(negedge clk);
        chk("trig_lost_alarm", 16'(alarm_on), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        alarm_trig = 1'b1;
        @(negedge clk);
        alarm_trig = 1'b0;
        chk("trig_ok_alarm",  16'(alarm_on), 16'd1);
        chk("trig_ok_hits",   16'(hits), 16'd0);
        chk("trig_ok_rounds", 16'(rounds), 16'd0);
        chk("no_extra_done",  16'(gd_cnt), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
